mcpu_ctrl: RTL

//   Multi-cycle MIPS control unit, the successor to the single-cycle decoder. A Moore FSM sequences
//   IF/ID/EX/MEM/WB per instruction, stalls memory states on MIO_ready, times out hung bus accesses,
//   and traps illegal opcodes/functs. It drives the shared-memory multi-cycle datapath (single
//   ALU, IR, PC).

---
 rtl/mcpu_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcpu_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl -- multi-cycle MIPS control unit (Moore FSM)
//
// Sequences IF/ID/EX/MEM/WB for the shared-memory multi-cycle datapath.
// Memory states (IF, MRD, MWR) stall on MIO_ready and trap a hung bus once
// MIO_TIMEOUT consecutive not-ready cycles have elapsed. Illegal opcodes or
// R-type functs also land in the sticky TRAP state, which only rst leaves.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   OPcode, Fun         IR[31:26] and IR[5:0]
//   zero                ALU zero flag (consumed by datapath via PCWriteCond)
//   MIO_ready           memory/IO access completes this cycle
//   PCWrite .. RegDst   datapath strobes and 1-bit selects
//   ALUSrcB, PCSource   2-bit datapath selects
//   ALU_Control         3-bit ALU operation
//   CPU_MIO             bus request
//   state               current state code (debug)
//   trap                sticky illegal-instruction / bus-timeout flag
// ---------------------------------------------------------------------------
module mcpu_ctrl #(
    parameter int MIO_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       mem_w,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_Control,
    output logic       CPU_MIO,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_IF   = 4'h0,
        S_ID   = 4'h1,
        S_MA   = 4'h2,
        S_MRD  = 4'h3,
        S_LWB  = 4'h4,
        S_MWR  = 4'h5,
        S_EXR  = 4'h6,
        S_RWB  = 4'h7,
        S_BEQ  = 4'h8,
        S_JMP  = 4'h9,
        S_EXI  = 4'hA,
        S_IWB  = 4'hB,
        S_TRAP = 4'hF
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Last counter value before a timeout; guarded so MIO_TIMEOUT=0 is legal.
    localparam int               TO_LAST_I = (MIO_TIMEOUT == 0) ? 0 : MIO_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       fun_ok;
    logic [2:0] fun_alu;
    logic [2:0] imm_alu;
    logic       wait_st;
    logic       timeout;

    // R-type funct decode: legality and ALU operation in one table.
    always_comb begin
        fun_ok  = 1'b1;
        fun_alu = ALU_ADD;
        case (Fun)
            6'b100000: fun_alu = ALU_ADD;
            6'b100010: fun_alu = ALU_SUB;
            6'b100100: fun_alu = ALU_AND;
            6'b100101: fun_alu = ALU_OR;
            6'b101010: fun_alu = ALU_SLT;
            6'b100111: fun_alu = ALU_NOR;
            6'b000010: fun_alu = ALU_SRL;
            6'b100110: fun_alu = ALU_XOR;
            default:   fun_ok  = 1'b0;
        endcase
    end

    assign imm_alu = (OPcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
    assign wait_st = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
    // A ready on the final allowed cycle still advances normally.
    assign timeout = (MIO_TIMEOUT != 0) && wait_st && !MIO_ready && (cnt_q == TO_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  if (MIO_ready) state_d = S_ID;
            S_ID: begin
                case (OPcode)
                    OP_RTYPE:       state_d = fun_ok ? S_EXR : S_TRAP;
                    OP_LW, OP_SW:   state_d = S_MA;
                    OP_BEQ:         state_d = S_BEQ;
                    OP_J:           state_d = S_JMP;
                    OP_ADDI,
                    OP_SLTI:        state_d = S_EXI;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MA:   state_d = (OPcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:  if (MIO_ready) state_d = S_LWB;
            S_LWB:  state_d = S_IF;
            S_MWR:  if (MIO_ready) state_d = S_IF;
            S_EXR:  state_d = S_RWB;
            S_RWB:  state_d = S_IF;
            S_BEQ:  state_d = S_IF;
            S_JMP:  state_d = S_IF;
            S_EXI:  state_d = S_IWB;
            S_IWB:  state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (timeout) state_d = S_TRAP;
    end

    // Wait counter: zero on entry to a memory state, counts not-ready cycles,
    // saturates instead of wrapping when no timeout is configured.
    always_comb begin
        cnt_d = '0;
        if ((state_d != state_q) &&
            (state_d == S_IF || state_d == S_MRD || state_d == S_MWR)) begin
            cnt_d = '0;
        end else if (wait_st && !MIO_ready) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode; IF's IRWrite/PCWrite are the only ready-gated strobes.
    // rst forces every output low immediately, independent of the clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        mem_w       = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALU_Control = ALU_ADD;
        CPU_MIO     = 1'b0;
        trap        = 1'b0;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID:  ALUSrcB = 2'b11;
            S_MA: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_LWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MWR: begin
                mem_w   = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_EXR: begin
                ALUSrcA     = 1'b1;
                ALU_Control = fun_alu;
            end
            S_RWB: begin
                RegDst      = 1'b1;
                RegWrite    = 1'b1;
                ALU_Control = fun_alu;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_EXI: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_Control = imm_alu;
            end
            S_IWB: begin
                RegWrite    = 1'b1;
                ALU_Control = imm_alu;
            end
            S_TRAP: trap = 1'b1;
            default: trap = 1'b1;
        endcase
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            mem_w       = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            ALU_Control = 3'b000;
            CPU_MIO     = 1'b0;
            trap        = 1'b0;
        end
    end

    assign state = state_q;

endmodule
